// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared constants and types for the pipeline stall/flush
//                controller: FSM state codes, the NOP pattern loaded by
//                flushed pipeline registers, and the control-bundle type.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int STATE_W    = 2;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [STATE_W-1:0] CTRL_IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] CTRL_MC_BUSY  = 2'd1;
    localparam logic [STATE_W-1:0] CTRL_BUS_HOLD = 2'd2;

    // addi x0, x0, 0 -- what IF/ID and ID/EX load when flushed
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    // One bit per pipeline-control output driven by the FSM output logic
    typedef struct packed {
        logic jump_en;
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic flush_if_id;
        logic flush_id_ex;
        logic mc_abort;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Full front-end freeze: PC, IF/ID and ID/EX all hold
    function automatic ctrl_t ctrl_freeze_all();
        ctrl_t c;
        c             = CTRL_NONE;
        c.stall_pc    = 1'b1;
        c.stall_if_id = 1'b1;
        c.stall_id_ex = 1'b1;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Bundle of core status inputs and pipeline control outputs
//                exchanged between the core datapath and pipe_ctrl.
//                master = controller side, slave = datapath side.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    // status from the datapath
    logic                  jump_en_i;
    logic [XLEN-1:0]       jump_addr_i;
    logic [REG_ADDR_W-1:0] id_rs1_addr_i;
    logic [REG_ADDR_W-1:0] id_rs2_addr_i;
    logic                  id_rs1_ren_i;
    logic                  id_rs2_ren_i;
    logic                  ex_is_load_i;
    logic [REG_ADDR_W-1:0] ex_rd_addr_i;
    logic                  ex_reg_wen_i;
    logic                  mc_start_i;
    logic                  mc_done_i;
    logic                  bus_hold_req_i;

    // controls back to the datapath
    logic                  jump_en_o;
    logic [XLEN-1:0]       jump_addr_o;
    logic                  stall_pc_o;
    logic                  stall_if_id_o;
    logic                  stall_id_ex_o;
    logic                  flush_if_id_o;
    logic                  flush_id_ex_o;
    logic                  mc_abort_o;
    logic [STATE_W-1:0]    state_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        input  jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_ren_i, id_rs2_ren_i, ex_is_load_i, ex_rd_addr_i,
               ex_reg_wen_i, mc_start_i, mc_done_i, bus_hold_req_i,
        output jump_en_o, jump_addr_o, stall_pc_o, stall_if_id_o,
               stall_id_ex_o, flush_if_id_o, flush_id_ex_o, mc_abort_o,
               state_o, stall_cnt_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_ren_i, id_rs2_ren_i, ex_is_load_i, ex_rd_addr_i,
               ex_reg_wen_i, mc_start_i, mc_done_i, bus_hold_req_i,
        input  jump_en_o, jump_addr_o, stall_pc_o, stall_if_id_o,
               stall_id_ex_o, flush_if_id_o, flush_id_ex_o, mc_abort_o,
               state_o, stall_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_hazard_detect
//  Description : Combinational load-use hazard compare between the
//                instruction in ID and a load in EX. x0 never hazards.
//                Kept standalone so a forwarding unit can reuse it.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  wire logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  wire logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  wire logic                  id_rs1_ren_i,
    input  wire logic                  id_rs2_ren_i,
    input  wire logic                  ex_is_load_i,
    input  wire logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  wire logic                  ex_reg_wen_i,
    output logic                       load_use_o
);

    logic w_rd_live;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A load result is only pending if it targets a real register
    always_comb begin
        w_rd_live  = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != '0);
        w_rs1_hit  = id_rs1_ren_i & (id_rs1_addr_i == ex_rd_addr_i);
        w_rs2_hit  = id_rs2_ren_i & (id_rs2_addr_i == ex_rd_addr_i);
        load_use_o = w_rd_live & (w_rs1_hit | w_rs2_hit);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central stall/flush controller for the 5-stage core.
//                Redirects the PC on EX jumps, inserts load-use bubbles,
//                freezes the front end during multi-cycle EX ops and bus
//                holds, aborts over-long multi-cycle ops, and counts
//                stalled cycles (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
)(
    input  wire logic    clk,
    input  wire logic    rst,
    pipe_ctrl_if.master  bus
);

    localparam int MC_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [MC_W-1:0]  C_MC_LAST = MC_W'(MC_TIMEOUT - 1);
    localparam logic [MC_W-1:0]  C_MC_ONE  = MC_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [MC_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic  w_load_use;
    logic  w_mc_expired;
    ctrl_t w_ctrl;

    pipe_ctrl_hazard_detect u_hazard (
        .id_rs1_addr_i (bus.id_rs1_addr_i),
        .id_rs2_addr_i (bus.id_rs2_addr_i),
        .id_rs1_ren_i  (bus.id_rs1_ren_i),
        .id_rs2_ren_i  (bus.id_rs2_ren_i),
        .ex_is_load_i  (bus.ex_is_load_i),
        .ex_rd_addr_i  (bus.ex_rd_addr_i),
        .ex_reg_wen_i  (bus.ex_reg_wen_i),
        .load_use_o    (w_load_use)
    );

    assign w_mc_expired = (mc_cnt_q == C_MC_LAST);

    // State register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CTRL_IDLE;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state selection; IDLE priority is jump > mc_start > bus_hold
    always_comb begin
        state_d = CTRL_IDLE;
        case (state_q)
            CTRL_IDLE: begin
                if (bus.jump_en_i)
                    state_d = bus.bus_hold_req_i ? CTRL_BUS_HOLD : CTRL_IDLE;
                else if (bus.mc_start_i)
                    state_d = CTRL_MC_BUSY;
                else if (bus.bus_hold_req_i)
                    state_d = CTRL_BUS_HOLD;
                else
                    state_d = CTRL_IDLE;
            end
            CTRL_MC_BUSY: begin
                if (bus.mc_done_i)
                    state_d = bus.bus_hold_req_i ? CTRL_BUS_HOLD : CTRL_IDLE;
                else if (w_mc_expired)
                    state_d = CTRL_IDLE;
                else
                    state_d = CTRL_MC_BUSY;
            end
            CTRL_BUS_HOLD: begin
                state_d = bus.bus_hold_req_i ? CTRL_BUS_HOLD : CTRL_IDLE;
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    // Pipeline control outputs decoded from state and same-cycle inputs
    always_comb begin
        w_ctrl = CTRL_NONE;
        case (state_q)
            CTRL_IDLE: begin
                if (bus.jump_en_i) begin
                    w_ctrl.jump_en     = 1'b1;
                    w_ctrl.flush_if_id = 1'b1;
                    w_ctrl.flush_id_ex = 1'b1;
                end else if (bus.mc_start_i || bus.bus_hold_req_i) begin
                    w_ctrl = ctrl_freeze_all();
                end else if (w_load_use) begin
                    // hold PC and IF/ID, push a bubble into EX
                    w_ctrl.stall_pc    = 1'b1;
                    w_ctrl.stall_if_id = 1'b1;
                    w_ctrl.flush_id_ex = 1'b1;
                end
            end
            CTRL_MC_BUSY: begin
                if (bus.mc_done_i) begin
                    w_ctrl = CTRL_NONE;
                end else if (w_mc_expired) begin
                    // drop the hung op: ID/EX gets a bubble instead of holding
                    w_ctrl.stall_pc    = 1'b1;
                    w_ctrl.stall_if_id = 1'b1;
                    w_ctrl.flush_id_ex = 1'b1;
                    w_ctrl.mc_abort    = 1'b1;
                end else begin
                    w_ctrl = ctrl_freeze_all();
                end
            end
            CTRL_BUS_HOLD: begin
                if (bus.bus_hold_req_i)
                    w_ctrl = ctrl_freeze_all();
            end
            default: w_ctrl = CTRL_NONE;
        endcase
    end

    // Multi-cycle timeout counter and saturating stall-cycle counter
    always_comb begin
        mc_cnt_d = '0;
        if (state_q == CTRL_MC_BUSY)
            mc_cnt_d = mc_cnt_q + C_MC_ONE;

        stall_cnt_d = stall_cnt_q;
        if (bus.stall_pc_o && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end

    // All decoded controls read as 0 while reset is held
    assign bus.jump_en_o     = w_ctrl.jump_en     & ~rst;
    assign bus.jump_addr_o   = rst ? '0 : bus.jump_addr_i;
    assign bus.stall_pc_o    = w_ctrl.stall_pc    & ~rst;
    assign bus.stall_if_id_o = w_ctrl.stall_if_id & ~rst;
    assign bus.stall_id_ex_o = w_ctrl.stall_id_ex & ~rst;
    assign bus.flush_if_id_o = w_ctrl.flush_if_id & ~rst;
    assign bus.flush_id_ex_o = w_ctrl.flush_id_ex & ~rst;
    assign bus.mc_abort_o    = w_ctrl.mc_abort    & ~rst;
    assign bus.state_o       = state_q;
    assign bus.stall_cnt_o   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl. dut_a uses the
//                default timeout/counter width; dut_b (MC_TIMEOUT=4, CNT_W=3)
//                sees identical inputs for the timeout and saturation cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(32)) ifa ();
    pipe_ctrl_if #(.CNT_W(3))  ifb ();

    assign ifb.jump_en_i      = ifa.jump_en_i;
    assign ifb.jump_addr_i    = ifa.jump_addr_i;
    assign ifb.id_rs1_addr_i  = ifa.id_rs1_addr_i;
    assign ifb.id_rs2_addr_i  = ifa.id_rs2_addr_i;
    assign ifb.id_rs1_ren_i   = ifa.id_rs1_ren_i;
    assign ifb.id_rs2_ren_i   = ifa.id_rs2_ren_i;
    assign ifb.ex_is_load_i   = ifa.ex_is_load_i;
    assign ifb.ex_rd_addr_i   = ifa.ex_rd_addr_i;
    assign ifb.ex_reg_wen_i   = ifa.ex_reg_wen_i;
    assign ifb.mc_start_i     = ifa.mc_start_i;
    assign ifb.mc_done_i      = ifa.mc_done_i;
    assign ifb.bus_hold_req_i = ifa.bus_hold_req_i;

    pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pipe_ctrl #(.MC_TIMEOUT(4),  .CNT_W(3))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        ifa.jump_en_i      = 1'b0;
        ifa.jump_addr_i    = '0;
        ifa.id_rs1_addr_i  = '0;
        ifa.id_rs2_addr_i  = '0;
        ifa.id_rs1_ren_i   = 1'b0;
        ifa.id_rs2_ren_i   = 1'b0;
        ifa.ex_is_load_i   = 1'b0;
        ifa.ex_rd_addr_i   = '0;
        ifa.ex_reg_wen_i   = 1'b0;
        ifa.mc_start_i     = 1'b0;
        ifa.mc_done_i      = 1'b0;
        ifa.bus_hold_req_i = 1'b0;
    endtask

    // inputs change 1 time unit after the rising edge, checks 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic r1en, input logic [4:0] rs2, input logic r2en);
        ifa.ex_is_load_i  = 1'b1;
        ifa.ex_reg_wen_i  = 1'b1;
        ifa.ex_rd_addr_i  = rd;
        ifa.id_rs1_addr_i = rs1;
        ifa.id_rs1_ren_i  = r1en;
        ifa.id_rs2_addr_i = rs2;
        ifa.id_rs2_ren_i  = r2en;
    endtask

    initial begin
        clr_in();
        // ---- reset: outputs forced low even with active inputs
        ifa.jump_en_i      = 1'b1;
        ifa.jump_addr_i    = 32'hDEAD_BEEF;
        ifa.bus_hold_req_i = 1'b1;
        repeat (2) tick();
        chk("rst_jump_en", ifa.jump_en_o, 1'b0);
        chk("rst_jump_addr", ifa.jump_addr_o, 32'h0);
        chk("rst_stall_pc", ifa.stall_pc_o, 1'b0);
        chk("rst_state", ifa.state_o, 2'd0);
        chk("rst_cnt", ifa.stall_cnt_o, 32'd0);
        clr_in();
        rst = 1'b0;
        #1;

        // ---- load-use on rs1
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        chk("lu_stall_pc", ifa.stall_pc_o, 1'b1);
        chk("lu_stall_ifid", ifa.stall_if_id_o, 1'b1);
        chk("lu_flush_idex", ifa.flush_id_ex_o, 1'b1);
        chk("lu_stall_idex", ifa.stall_id_ex_o, 1'b0);
        tick();
        clr_in();
        #1;
        chk("lu_after_stall", ifa.stall_pc_o, 1'b0);
        chk("lu_after_flush", ifa.flush_id_ex_o, 1'b0);
        chk("lu_cnt", ifa.stall_cnt_o, 32'd1);

        // ---- rd = x0 never stalls
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        chk("x0_stall_pc", ifa.stall_pc_o, 1'b0);
        chk("x0_flush", ifa.flush_id_ex_o, 1'b0);
        // ---- rs2 match but not read -> no stall
        set_load(5'd7, 5'd1, 1'b1, 5'd7, 1'b0);
        #1;
        chk("rs2_noren", ifa.stall_pc_o, 1'b0);
        // ---- rs2 match and read -> stall
        ifa.id_rs2_ren_i = 1'b1;
        #1;
        chk("rs2_stall", ifa.stall_pc_o, 1'b1);
        // ---- not a load -> no stall
        ifa.ex_is_load_i = 1'b0;
        #1;
        chk("noload", ifa.stall_pc_o, 1'b0);
        ifa.ex_is_load_i = 1'b1;
        tick();
        clr_in();
        #1;
        chk("cnt_after_rs2", ifa.stall_cnt_o, 32'd2);

        // ---- jump beats load-use and mc_start
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        ifa.jump_en_i   = 1'b1;
        ifa.jump_addr_i = 32'h0000_0100;
        ifa.mc_start_i  = 1'b1;
        #1;
        chk("j_en", ifa.jump_en_o, 1'b1);
        chk("j_addr", ifa.jump_addr_o, 32'h100);
        chk("j_flush_ifid", ifa.flush_if_id_o, 1'b1);
        chk("j_flush_idex", ifa.flush_id_ex_o, 1'b1);
        chk("j_stall_pc", ifa.stall_pc_o, 1'b0);
        chk("j_stall_idex", ifa.stall_id_ex_o, 1'b0);
        tick();
        clr_in();
        #1;
        chk("j_state", ifa.state_o, 2'd0);

        // ---- jump with bus hold goes to BUS_HOLD
        ifa.jump_en_i      = 1'b1;
        ifa.bus_hold_req_i = 1'b1;
        #1;
        chk("jh_en", ifa.jump_en_o, 1'b1);
        chk("jh_stall", ifa.stall_pc_o, 1'b0);
        tick();
        ifa.jump_en_i = 1'b0;
        #1;
        chk("jh_state", ifa.state_o, 2'd2);
        chk("jh_hold_stall", ifa.stall_if_id_o, 1'b1);
        ifa.bus_hold_req_i = 1'b0;
        #1;
        chk("jh_release", ifa.stall_pc_o, 1'b0);
        tick();
        chk("jh_idle", ifa.state_o, 2'd0);

        // ---- multi-cycle op, done 5 cycles after start
        do_reset();
        ifa.mc_start_i = 1'b1;
        #1;
        chk("mc_start_stall_pc", ifa.stall_pc_o, 1'b1);
        chk("mc_start_stall_idex", ifa.stall_id_ex_o, 1'b1);
        chk("mc_start_state", ifa.state_o, 2'd0);
        tick();
        clr_in();
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("mc_busy_state", ifa.state_o, 2'd1);
            chk("mc_busy_stall", ifa.stall_id_ex_o, 1'b1);
            tick();
        end
        ifa.mc_done_i = 1'b1;
        #1;
        chk("mc_done_stall", ifa.stall_pc_o, 1'b0);
        chk("mc_done_state", ifa.state_o, 2'd1);
        tick();
        clr_in();
        #1;
        chk("mc_end_state", ifa.state_o, 2'd0);
        chk("mc_cnt", ifa.stall_cnt_o, 32'd5);

        // ---- timeout on dut_b (MC_TIMEOUT=4)
        do_reset();
        ifa.mc_start_i = 1'b1;
        tick();
        clr_in();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("to_busy_abort", ifb.mc_abort_o, 1'b0);
            chk("to_busy_state", ifb.state_o, 2'd1);
            tick();
        end
        #1;
        chk("to_abort", ifb.mc_abort_o, 1'b1);
        chk("to_flush_idex", ifb.flush_id_ex_o, 1'b1);
        chk("to_stall_idex", ifb.stall_id_ex_o, 1'b0);
        chk("to_a_no_abort", ifa.mc_abort_o, 1'b0);
        tick();
        #1;
        chk("to_state", ifb.state_o, 2'd0);
        chk("to_abort_pulse", ifb.mc_abort_o, 1'b0);
        chk("to_cnt", ifb.stall_cnt_o, 3'd5);

        // ---- bus hold raised during MC_BUSY, then done
        do_reset();
        ifa.mc_start_i = 1'b1;
        tick();
        clr_in();
        ifa.bus_hold_req_i = 1'b1;
        tick();
        ifa.mc_done_i = 1'b1;
        #1;
        chk("mh_done_state", ifa.state_o, 2'd1);
        chk("mh_done_stall", ifa.stall_pc_o, 1'b0);
        tick();
        ifa.mc_done_i = 1'b0;
        #1;
        chk("mh_hold_state", ifa.state_o, 2'd2);
        chk("mh_hold_stall", ifa.stall_pc_o, 1'b1);
        tick();
        chk("mh_hold_state2", ifa.state_o, 2'd2);
        ifa.bus_hold_req_i = 1'b0;
        #1;
        chk("mh_release_stall", ifa.stall_id_ex_o, 1'b0);
        tick();
        chk("mh_idle", ifa.state_o, 2'd0);

        // ---- reset asserted mid-MC_BUSY
        do_reset();
        ifa.mc_start_i = 1'b1;
        tick();
        clr_in();
        ifa.bus_hold_req_i = 1'b1;
        #1;
        chk("rm_busy", ifa.state_o, 2'd1);
        chk("rm_cnt_before", ifa.stall_cnt_o, 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_stall_now", ifa.stall_pc_o, 1'b0);
        chk("rm_state_now", ifa.state_o, 2'd0);
        tick();
        ifa.bus_hold_req_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("rm_state_after", ifa.state_o, 2'd0);
        chk("rm_cnt_after", ifa.stall_cnt_o, 32'd0);

        // ---- long bus hold saturates the 3-bit counter
        ifa.bus_hold_req_i = 1'b1;
        repeat (10) tick();
        chk("sat_b", ifb.stall_cnt_o, 3'd7);
        chk("sat_a", ifa.stall_cnt_o, 32'd10);
        ifa.bus_hold_req_i = 1'b0;
        tick();
        chk("sat_b_hold", ifb.stall_cnt_o, 3'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
